mult_div_unit: RTL and testbench
================================

# mult_div_unit

Iterative multiply/divide unit with architectural HI/LO registers for the MIPS datapath. It executes MULT, MULTU, DIV and DIVU over a parametrised operand width, one bit per cycle. The main ALU stays single-cycle. The unit sits beside the ALU in the execute stage. The hazard unit stalls the pipeline on `busy`, and MFHI/MFLO read `hi`/`lo` directly. MTHI/MTLO write HI/LO directly.

## Interface
- `WIDTH`, default 32: operand width in bits. Must be ≥ 4. HI and LO are each `WIDTH` bits.
- `CLK`  in  1  rising-edge clock.
- `nRST`  in  1  asynchronous, active-low reset.
- `start`  in  1  request an operation. Sampled only in IDLE.
- `op`  in  2  operation code: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU. Sampled with `start`.
- `rs_data`  in  WIDTH  multiplicand / dividend.
- `rt_data`  in  WIDTH  multiplier / divisor.
- `abort`  in  1  kills an in-flight operation (pipeline flush).
- `hi_wen`, `lo_wen`  in  1 each  MTHI / MTLO write enables.
- `wdata`  in  WIDTH  MTHI / MTLO write data.
- `busy`  out  1  an operation is in flight.
- `done`  out  1  one-cycle pulse. HI/LO are updated with the result in that same cycle.
- `hi`, `lo`  out  WIDTH each  architectural HI/LO registers.

## Operation
- States: IDLE, RUN, FIX.
- IDLE → RUN on `start`:
  - Latch `op`.
  - Latch operand magnitudes: absolute values for signed ops, raw values for unsigned ops.
  - Latch sign flags:
    - `neg_q` = sign(rs) XOR sign(rt).
    - `neg_r` = sign(rs).
  - Clear the iteration counter. The counter is $clog2(WIDTH+1) bits.
- RUN performs one iteration per cycle, for exactly WIDTH cycles, then goes to FIX.
  - Multiply: shift-add into a 2·WIDTH-bit accumulator, LSB of multiplier first.
  - Divide: restoring, MSB of dividend first. The partial remainder is WIDTH+1 bits.
- FIX → IDLE: apply sign correction, write HI/LO, and pulse `done`.
  - Signed multiply: negate the 2·WIDTH-bit product if `neg_q`. HI = upper half, LO = lower half.
  - Signed divide: negate the quotient if `neg_q` and negate the remainder if `neg_r`. LO = quotient, HI = remainder.
- Divide by zero (rt = 0, any divide op): the core runs normally and produces LO = all ones, HI = rs.
  - Signed ops then apply sign correction per the normal rule. Example: DIV 5/0 → LO = 0xFFFFFFFF, HI = 5.
  - This result is defined behaviour. No exception is raised.
- Signed overflow, most-negative / −1: LO = most-negative, HI = 0. This is the natural wrap of the magnitude path.
- Multiply results never overflow: the full 2·WIDTH product is kept.
- `start` while `busy` is ignored.
- `abort` in RUN or FIX:
  - Return to IDLE at the next edge.
  - HI/LO keep their prior values and no `done` pulse occurs.
  - `abort` has priority over FIX completion in the same cycle.
- `hi_wen` / `lo_wen`:
  - In IDLE they write `wdata` at the edge.
  - While `busy` they are ignored.
  - If asserted together with `start`, the write takes effect. The operation's result later overwrites it.
- Reset (`nRST` low, at any time, including mid-operation):
  - State = IDLE.
  - `busy` = 0, `done` = 0, `hi` = 0, `lo` = 0, counter = 0.
  - Reset takes effect asynchronously.

## Timing
- Start edge E0 samples `start`. `busy` is 1 from after E0 until after E(WIDTH+1).
- Edges E1..E(WIDTH) are iterations. FIX completes at E(WIDTH+1).
- After E(WIDTH+1): `done` = 1 for one cycle, `busy` = 0, and `hi`/`lo` hold the result.
- Latency is WIDTH+1 cycles from the start edge to `done` (33 for WIDTH = 32).
- `busy` and `done` are registered outputs and are never high together.
- In the `done` cycle the unit is IDLE, so a new `start` there is accepted (back-to-back issue).
- `hi`/`lo` outputs change only at: an MTHI/MTLO edge in IDLE, the FIX completion edge, or reset.

## Test plan
- MULTU 0xFFFFFFFF × 0xFFFFFFFF (WIDTH = 32) → HI = 0xFFFFFFFE, LO = 0x00000001. `done` exactly 33 cycles after the start edge; `busy` high for cycles 1–33.
- MULT −3 × 7 → HI = 0xFFFFFFFF, LO = 0xFFFFFFEB. Then back-to-back MULT 0x80000000 × 0x80000000, issued in the `done` cycle → HI = 0x40000000, LO = 0.
- DIV −7 / 2 → LO = 0xFFFFFFFD, HI = 0xFFFFFFFF. DIVU 7 / 2 → LO = 3, HI = 1.
- DIV 0x80000000 / 0xFFFFFFFF → LO = 0x80000000, HI = 0. DIVU 0x1234 / 0 → LO = 0xFFFFFFFF, HI = 0x1234.
- MTHI 0xAAAA0000 in IDLE → `hi` updates next edge.
  - During a DIV: MTLO is ignored and a second `start` is ignored.
  - `abort` at iteration 10 → `busy` low after the next edge, no `done`, `hi` = 0xAAAA0000 unchanged.
- `nRST` pulsed low at iteration 5 of a MULT → `busy`, `done`, `hi`, `lo` go to 0 immediately without a clock edge. A MULTU 6 × 7 after release → LO = 42, HI = 0.
- Repeat the directed cases with WIDTH = 8 against a reference model: random signed and unsigned operands, latency 9.

Source files
------------

// File: rtl/mult_div_unit.sv
// Iterative multiply/divide unit holding the architectural HI/LO registers.
// MULT/MULTU use shift-add and DIV/DIVU use restoring division.
// Both retire one operand bit per cycle on operand magnitudes, and the sign
// is fixed up in a final FIX cycle.
//
// Handshake: `start` is accepted only when the unit is IDLE (busy == 0).
// `busy` stays high until the FIX completion edge. `done` then pulses for one
// cycle with HI/LO already holding the result; the unit is IDLE again in that
// cycle. `abort` drops an in-flight operation without touching HI/LO.
module mult_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] rs_data,
    input  logic [WIDTH-1:0] rt_data,
    input  logic             abort,
    input  logic             hi_wen,
    input  logic             lo_wen,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic [1:0]       dbg_state
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIX  = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [1:0]          op_q, op_d;
    // acc low half: the multiplier or dividend, consumed one bit per cycle.
    // For divide it fills with quotient bits.
    // acc high half: the running product; it stays zero for divide.
    logic [2*WIDTH-1:0]  acc_q, acc_d;
    // Multiplicand magnitude for multiply, divisor magnitude for divide
    logic [WIDTH-1:0]    opnd_q, opnd_d;
    logic [WIDTH-1:0]    rem_q, rem_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic                neg_quo_q, neg_quo_d;
    logic                neg_rem_q, neg_rem_d;
    logic [WIDTH-1:0]    hi_q, hi_d;
    logic [WIDTH-1:0]    lo_q, lo_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;

    logic                op_signed;
    logic [WIDTH-1:0]    rs_mag;
    logic [WIDTH-1:0]    rt_mag;
    logic [WIDTH:0]      mul_sum;
    logic [WIDTH:0]      div_shift;
    logic                div_ge;
    logic                fix_signed;
    logic [2*WIDTH-1:0]  prod_fix;
    logic [WIDTH-1:0]    quo_fix;
    logic [WIDTH-1:0]    rem_fix;

    // Operand magnitudes: signed ops take the absolute value; unsigned ops pass through.
    // The most negative value maps to itself, which is its correct unsigned magnitude.
    assign op_signed = ~op[0];
    assign rs_mag    = (op_signed && rs_data[WIDTH-1]) ? (~rs_data + 1'b1) : rs_data;
    assign rt_mag    = (op_signed && rt_data[WIDTH-1]) ? (~rt_data + 1'b1) : rt_data;

    // Multiply step: conditionally add the multiplicand into the upper half.
    // The carry-out bit is kept and shifted down with the rest of the accumulator.
    assign mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
                     + {1'b0, (acc_q[0] ? opnd_q : {WIDTH{1'b0}})};

    // Divide step: the WIDTH+1 bit partial remainder is the previous remainder
    // with the next dividend bit shifted in.
    // When it is >= divisor, the difference fits in WIDTH bits.
    assign div_shift = {rem_q, acc_q[WIDTH-1]};
    assign div_ge    = div_shift >= {1'b0, opnd_q};

    // Sign correction applied in FIX. Divide by zero and the overflow case
    // fall out of the same rule without special handling.
    assign fix_signed = ~op_q[0];
    assign prod_fix   = (fix_signed && neg_quo_q) ? (~acc_q + 1'b1) : acc_q;
    assign quo_fix    = (fix_signed && neg_quo_q) ? (~acc_q[WIDTH-1:0] + 1'b1)
                                                  : acc_q[WIDTH-1:0];
    assign rem_fix    = (fix_signed && neg_rem_q) ? (~rem_q + 1'b1) : rem_q;

    // Next-state logic: FSM sequencing, datapath iteration and HI/LO writes
    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        acc_d     = acc_q;
        opnd_d    = opnd_q;
        rem_d     = rem_q;
        cnt_d     = cnt_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        done_d    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (hi_wen) hi_d = wdata;
                if (lo_wen) lo_d = wdata;
                if (start) begin
                    state_d   = ST_RUN;
                    op_d      = op;
                    acc_d     = {{WIDTH{1'b0}}, rs_mag};
                    opnd_d    = rt_mag;
                    rem_d     = '0;
                    cnt_d     = '0;
                    neg_quo_d = op_signed & (rs_data[WIDTH-1] ^ rt_data[WIDTH-1]);
                    neg_rem_d = op_signed & rs_data[WIDTH-1];
                end
            end
            ST_RUN: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else begin
                    if (op_q[1]) begin
                        rem_d = div_ge ? (div_shift[WIDTH-1:0] - opnd_q)
                                       : div_shift[WIDTH-1:0];
                        acc_d = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-2:0], div_ge};
                    end else begin
                        acc_d = {mul_sum, acc_q[WIDTH-1:1]};
                    end
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == LAST) state_d = ST_FIX;
                end
            end
            ST_FIX: begin
                state_d = ST_IDLE;
                if (!abort) begin
                    done_d = 1'b1;
                    if (op_q[1]) begin
                        lo_d = quo_fix;
                        hi_d = rem_fix;
                    end else begin
                        hi_d = prod_fix[2*WIDTH-1:WIDTH];
                        lo_d = prod_fix[WIDTH-1:0];
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    // State and datapath registers with asynchronous active-low reset
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q   <= ST_IDLE;
            op_q      <= '0;
            acc_q     <= '0;
            opnd_q    <= '0;
            rem_q     <= '0;
            cnt_q     <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            acc_q     <= acc_d;
            opnd_q    <= opnd_d;
            rem_q     <= rem_d;
            cnt_q     <= cnt_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign hi        = hi_q;
    assign lo        = lo_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit: WIDTH=32 and WIDTH=8 instances side by side.
module tb_mult_div_unit;

    logic        CLK;
    logic        nRST;
    int          total;
    int          bad;
    int          cyc;

    // WIDTH = 32 instance signals
    logic        start32, abort32, hi_wen32, lo_wen32;
    logic [1:0]  op32;
    logic [31:0] rs32, rt32, wdata32, hi32, lo32;
    logic        busy32, done32;
    logic [1:0]  st32;
    int          e0_32;

    // WIDTH = 8 instance signals
    logic        start8, abort8, hi_wen8, lo_wen8;
    logic [1:0]  op8;
    logic [7:0]  rs8, rt8, wdata8, hi8, lo8;
    logic        busy8, done8;
    logic [1:0]  st8;
    int          e0_8;

    mult_div_unit #(.WIDTH(32)) u_dut32 (
        .CLK(CLK), .nRST(nRST), .start(start32), .op(op32),
        .rs_data(rs32), .rt_data(rt32), .abort(abort32),
        .hi_wen(hi_wen32), .lo_wen(lo_wen32), .wdata(wdata32),
        .busy(busy32), .done(done32), .hi(hi32), .lo(lo32), .dbg_state(st32)
    );

    mult_div_unit #(.WIDTH(8)) u_dut8 (
        .CLK(CLK), .nRST(nRST), .start(start8), .op(op8),
        .rs_data(rs8), .rt_data(rt8), .abort(abort8),
        .hi_wen(hi_wen8), .lo_wen(lo_wen8), .wdata(wdata8),
        .busy(busy8), .done(done8), .hi(hi8), .lo(lo8), .dbg_state(st8)
    );

    // clock / cycle counter
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // ---------------- WIDTH = 32 driver tasks ----------------
    task automatic issue32(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        @(negedge CLK);
        start32 = 1'b1; op32 = o; rs32 = a; rt32 = b;
        @(posedge CLK);
        #1;
        e0_32 = cyc;
        start32 = 1'b0;
    endtask

    task automatic wait_done32(output int lat, output int bcnt);
        int lim;
        lim  = cyc + 100;
        bcnt = busy32 ? 1 : 0;
        while (!done32 && cyc < lim) begin
            @(posedge CLK);
            #1;
            if (busy32) bcnt++;
        end
        if (!done32) check("timeout32", {63'd0, done32}, 64'd1);
        lat = cyc - e0_32;
    endtask

    task automatic op_check32(input string tag, input logic [1:0] o, input logic [31:0] a,
                              input logic [31:0] b, input logic [31:0] eh, input logic [31:0] el);
        int lat, bc;
        issue32(o, a, b);
        wait_done32(lat, bc);
        check({tag, "_hi"}, {32'd0, hi32}, {32'd0, eh});
        check({tag, "_lo"}, {32'd0, lo32}, {32'd0, el});
        check({tag, "_lat"}, 64'(lat), 64'd33);
    endtask

    // ---------------- WIDTH = 8 driver tasks and model ----------------
    function automatic logic [15:0] ref8(input logic [1:0] o, input logic [7:0] a, input logic [7:0] b);
        int sa, sb, p, q, r;
        logic [15:0] res;
        sa = int'($signed(a));
        sb = int'($signed(b));
        res = '0;
        case (o)
            2'b00: begin p = sa * sb; res = p[15:0]; end
            2'b01: begin p = int'(a) * int'(b); res = p[15:0]; end
            2'b10: begin
                if (b == 8'h00)                      res = {a, (a[7] ? 8'h01 : 8'hFF)};
                else if (a == 8'h80 && b == 8'hFF)   res = {8'h00, 8'h80};
                else begin
                    q = sa / sb; r = sa % sb;
                    res = {r[7:0], q[7:0]};
                end
            end
            default: begin
                if (b == 8'h00) res = {a, 8'hFF};
                else res = {a % b, a / b};
            end
        endcase
        return res;
    endfunction

    task automatic op_check8(input string tag, input logic [1:0] o, input logic [7:0] a, input logic [7:0] b);
        int lim, lat;
        logic [15:0] e;
        e = ref8(o, a, b);
        @(negedge CLK);
        start8 = 1'b1; op8 = o; rs8 = a; rt8 = b;
        @(posedge CLK);
        #1;
        e0_8 = cyc;
        start8 = 1'b0;
        lim = cyc + 40;
        while (!done8 && cyc < lim) begin
            @(posedge CLK);
            #1;
        end
        if (!done8) check({tag, "_timeout"}, {63'd0, done8}, 64'd1);
        lat = cyc - e0_8;
        $display("w8 %s op=%0d a=%0h b=%0h hi=%0h lo=%0h", tag, o, a, b, hi8, lo8);
        check({tag, "_hilo"}, {48'd0, hi8, lo8}, {48'd0, e});
        check({tag, "_lat"}, 64'(lat), 64'd9);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int lat, bc;
        logic [1:0] ro;
        logic [7:0] ra, rb;
        total = 0; bad = 0; cyc = 0;
        start32 = 0; abort32 = 0; hi_wen32 = 0; lo_wen32 = 0; op32 = 0; rs32 = 0; rt32 = 0; wdata32 = 0;
        start8 = 0; abort8 = 0; hi_wen8 = 0; lo_wen8 = 0; op8 = 0; rs8 = 0; rt8 = 0; wdata8 = 0;
        nRST = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        check("rst_busy", {63'd0, busy32}, 64'd0);
        check("rst_done", {63'd0, done32}, 64'd0);
        check("rst_hilo", {hi32, lo32}, 64'd0);
        check("rst_state", {62'd0, st32}, 64'd0);
        @(negedge CLK);
        nRST = 1'b1;

        // MULTU max * max, with latency and busy-width checks
        issue32(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF);
        wait_done32(lat, bc);
        check("multu_max_hi", {32'd0, hi32}, 64'hFFFFFFFE);
        check("multu_max_lo", {32'd0, lo32}, 64'h00000001);
        check("multu_max_lat", 64'(lat), 64'd33);
        check("multu_max_busy_cycles", 64'(bc), 64'd33);
        check("done_busy_exclusive", {63'd0, busy32}, 64'd0);
        @(posedge CLK);
        #1;
        check("done_one_cycle", {63'd0, done32}, 64'd0);

        // MULT -3*7, then back-to-back issue in the done cycle
        op_check32("mult_neg", 2'b00, 32'hFFFFFFFD, 32'd7, 32'hFFFFFFFF, 32'hFFFFFFEB);
        op_check32("mult_b2b", 2'b00, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000);

        op_check32("div_neg", 2'b10, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD);
        op_check32("divu_7_2", 2'b11, 32'd7, 32'd2, 32'd1, 32'd3);
        op_check32("div_ovf", 2'b10, 32'h80000000, 32'hFFFFFFFF, 32'd0, 32'h80000000);
        op_check32("divu_by0", 2'b11, 32'h1234, 32'd0, 32'h1234, 32'hFFFFFFFF);
        op_check32("div_by0", 2'b10, 32'd5, 32'd0, 32'd5, 32'hFFFFFFFF);

        // MTLO and a second start while busy are both ignored
        issue32(2'b10, 32'd100, 32'd7);
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        lo_wen32 = 1'b1; wdata32 = 32'h5555; start32 = 1'b1; op32 = 2'b01; rs32 = 32'd3; rt32 = 32'd3;
        @(posedge CLK);
        #1;
        lo_wen32 = 1'b0; start32 = 1'b0;
        check("mtlo_busy_ignored", {32'd0, lo32}, 64'hFFFFFFFF);
        wait_done32(lat, bc);
        check("div_stray_hi", {32'd0, hi32}, 64'd2);
        check("div_stray_lo", {32'd0, lo32}, 64'd14);
        check("div_stray_lat", 64'(lat), 64'd33);

        // MTHI in IDLE takes effect at the edge
        @(negedge CLK);
        hi_wen32 = 1'b1; wdata32 = 32'hAAAA0000;
        #1;
        check("mthi_before_edge", {32'd0, hi32}, 64'd2);
        @(posedge CLK);
        #1;
        hi_wen32 = 1'b0;
        check("mthi", {32'd0, hi32}, 64'hAAAA0000);

        // abort at iteration 10 of a DIV
        issue32(2'b10, 32'd1000, 32'd3);
        repeat (9) @(posedge CLK);
        @(negedge CLK);
        abort32 = 1'b1;
        @(posedge CLK);
        #1;
        abort32 = 1'b0;
        check("abort_busy", {63'd0, busy32}, 64'd0);
        check("abort_state", {62'd0, st32}, 64'd0);
        bc = 0;
        repeat (40) begin
            @(posedge CLK);
            #1;
            if (done32) bc++;
        end
        check("abort_no_done", 64'(bc), 64'd0);
        check("abort_hi_kept", {32'd0, hi32}, 64'hAAAA0000);
        check("abort_lo_kept", {32'd0, lo32}, 64'd14);

        // asynchronous reset at iteration 5 of a MULT
        issue32(2'b00, 32'd12345, 32'd678);
        repeat (5) @(posedge CLK);
        #3;
        nRST = 1'b0;
        #1;
        check("arst_busy", {63'd0, busy32}, 64'd0);
        check("arst_done", {63'd0, done32}, 64'd0);
        check("arst_hilo", {hi32, lo32}, 64'd0);
        @(negedge CLK);
        nRST = 1'b1;
        op_check32("multu_6_7", 2'b01, 32'd6, 32'd7, 32'd0, 32'd42);

        // WIDTH = 8: directed cases then random operands against the model
        op_check8("w8_multu_max", 2'b01, 8'hFF, 8'hFF);
        op_check8("w8_mult_neg", 2'b00, 8'hFD, 8'h07);
        op_check8("w8_mult_min", 2'b00, 8'h80, 8'h80);
        op_check8("w8_div_neg", 2'b10, 8'hF9, 8'h02);
        op_check8("w8_divu", 2'b11, 8'h07, 8'h02);
        op_check8("w8_div_ovf", 2'b10, 8'h80, 8'hFF);
        op_check8("w8_divu_by0", 2'b11, 8'h34, 8'h00);
        op_check8("w8_div_negby0", 2'b10, 8'hFB, 8'h00);
        for (int i = 0; i < 16; i++) begin
            ro = 2'($urandom_range(0, 3));
            ra = 8'($urandom_range(0, 255));
            rb = 8'($urandom_range(0, 255));
            op_check8("w8_rand", ro, ra, rb);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
